// File: rtl/lock_controller.sv
// Combination-lock entry controller: detects button presses, checks the entered
// digits against CODE, holds the pass/fail result, and locks out after repeated fails.
module lock_controller #(
  parameter logic [7:0] CODE           = 8'b11_10_01_00,
  parameter int         CODE_LEN       = 4,
  parameter int         HOLD_CYCLES    = 250000,
  parameter int         TIMEOUT_CYCLES = 25000000,
  parameter int         MAX_FAILS      = 3,
  parameter int         LOCKOUT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic [1:0] status,
  output logic [3:0] count,
  output logic       unlock
);

  localparam int MAX_HT  = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_HT > LOCKOUT_CYCLES) ? MAX_HT : LOCKOUT_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int FW      = $clog2(MAX_FAILS + 1);

  // Encoding doubles as the status output.
  typedef enum logic [1:0] {ENTER = 2'b00, FAIL = 2'b01, SUCCESS = 2'b10, LOCKOUT = 2'b11} state_e;

  state_e          state_q, state_d;
  logic [3:0]      btn_q, btn_d;
  logic [3:0]      count_q, count_d;
  logic            mismatch_q, mismatch_d;
  logic [FW-1:0]   fail_cnt_q, fail_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            unlock_q, unlock_d;

  logic [3:0] rise;
  logic       press;
  logic [1:0] digit;
  logic [1:0] code_digit;
  logic       wrong;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ENTER;
      btn_q      <= 4'hF;
      count_q    <= '0;
      mismatch_q <= 1'b0;
      fail_cnt_q <= '0;
      timer_q    <= '0;
      unlock_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn_d;
      count_q    <= count_d;
      mismatch_q <= mismatch_d;
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
      unlock_q   <= unlock_d;
    end
  end

  always_comb begin
    rise  = btn & ~btn_q;
    press = |rise;
    digit = 2'd0;
    for (int k = 0; k < 4; k++)
      if (rise[k]) digit = 2'(k);
    code_digit = CODE[{count_q[1:0], 1'b0} +: 2];
    // Several buttons rising together count as one press of a wrong digit.
    wrong = !$onehot(rise) || (digit != code_digit);

    state_d    = state_q;
    btn_d      = btn;
    count_d    = count_q;
    mismatch_d = mismatch_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q + 1'b1;
    unlock_d   = 1'b0;

    case (state_q)
      ENTER: begin
        if (press) begin
          count_d    = count_q + 1'b1;
          mismatch_d = mismatch_q | wrong;
          timer_d    = '0;
          if (count_q == 4'(CODE_LEN - 1)) begin
            if (!mismatch_d) begin
              state_d    = SUCCESS;
              unlock_d   = 1'b1;
              fail_cnt_d = '0;
            end else begin
              state_d    = FAIL;
              fail_cnt_d = fail_cnt_q + 1'b1;
            end
          end
        end else if (count_q == '0) begin
          timer_d = '0;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          count_d    = '0;
          mismatch_d = 1'b0;
          timer_d    = '0;
        end
      end
      SUCCESS, FAIL: begin
        if (timer_q == TW'(HOLD_CYCLES - 1)) begin
          timer_d    = '0;
          count_d    = '0;
          mismatch_d = 1'b0;
          state_d    = (state_q == FAIL && fail_cnt_q == FW'(MAX_FAILS)) ? LOCKOUT : ENTER;
        end
      end
      default: begin
        if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
          timer_d    = '0;
          fail_cnt_d = '0;
          state_d    = ENTER;
        end
      end
    endcase
  end

  always_comb begin
    status = state_q;
    count  = count_q;
    unlock = unlock_q;
  end

endmodule
